comp_sum_tree: RTL and testbench
================================

COMP_SUM_TREE -- requirements
Module: comp_sum_tree

Interface
REQ-001 Parameter N_IN, default 4, number of operands; SHALL be a power of two, 2..16.
REQ-002 Parameter WIDTH, default 16, operand and result width in bits; SHALL be in the range 1..64.
REQ-003 Derived constant LVL = log2(N_IN) SHALL set the adder-tree depth and the carry width.
REQ-004 clk  input  1  clock; all state changes occur on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand vector present.
REQ-007 in_ready  output  1  block accepts the operand vector this cycle.
REQ-008 vals  input  N_IN x WIDTH  operand array; vals[0] is operand 0.
REQ-009 sat_en  input  1  saturate mode, sampled with the operands; 0 selects wrap mode.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out  output  WIDTH  result.
REQ-013 carry  output  LVL  upper bits of the full-precision sum.
REQ-014 overflow  output  1  asserted when any carry bit is nonzero.

Function
REQ-015 The full sum SHALL be computed at WIDTH+LVL bits, so no bits are lost inside the tree.
REQ-016 Tree level k (k = 1..LVL) SHALL add adjacent pairs from level k-1 and register the partial sums, each partial sum widened by one bit.
REQ-017 sat_en and a valid bit SHALL travel alongside the data through every pipeline stage.
REQ-018 Latency SHALL be exactly LVL cycles from an accepted input to out_valid when no stall occurs.
REQ-019 An input SHALL be accepted on any cycle where in_valid=1 and in_ready=1.
REQ-020 Throughput SHALL be one vector per cycle whenever out_ready=1.
REQ-021 in_ready SHALL equal NOT(out_valid AND NOT out_ready).
- in_ready is combinational from out_valid and out_ready; it has no dependence on in_valid.
REQ-022 While in_ready=0, every pipeline register (data, valid, mode) SHALL hold its value.
REQ-023 While stalled, out, carry, overflow and out_valid SHALL stay stable.
REQ-024 Bubbles (in_valid=0 while in_ready=1) SHALL propagate as valid=0 slots.
- Bubbles are not compressed.
REQ-025 Wrap mode: out = sum[WIDTH-1:0]; carry = sum[WIDTH+LVL-1:WIDTH].
REQ-026 Saturate mode with overflow=1: out SHALL be all ones.
- carry and overflow still report the true upper bits.
REQ-027 Saturate mode with overflow=0: out SHALL equal the wrap-mode result.
REQ-028 When out_valid=0, out/carry/overflow are don't-care.
- They SHALL NOT be X after reset.
REQ-029 Operands SHALL be treated as unsigned.

Reset
REQ-030 Reset asserted SHALL immediately clear all valid bits, so out_valid=0 and in_ready=1.
REQ-031 Reset SHALL clear all data registers, so out=0, carry=0 and overflow=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight vectors; none SHALL emerge after reset release.
REQ-033 On the first rising edge after reset deasserts, an input presented with in_valid=1 SHALL be accepted.

Structure
REQ-034 Shared package comp_sum_pkg SHALL hold:
- a constant function returning log2 of a power of two;
- the sum_mode_e enum {MODE_WRAP, MODE_SAT}.
REQ-035 One sub-module, comp_sum_stage, SHALL implement one registered tree level.
- Parameters: input count and input width.
- Ports: clk, reset, a hold input, and a valid/mode sideband.
- comp_sum_tree SHALL instantiate LVL of these via generate.
REQ-036 Saturation and overflow logic SHALL sit in comp_sum_tree after the final stage, with the output registered by the final stage only.

Verification
REQ-037 N_IN=4, WIDTH=16, wrap mode: vals={1,2,3,4} -> after 2 cycles out=0x000A, carry=0, overflow=0.
REQ-038 N_IN=4, WIDTH=16, wrap mode: four operands of 0xFFFF -> out=0xFFFC, carry=2'b11, overflow=1.
- The same operands with sat_en=1 -> out=0xFFFF, carry=2'b11, overflow=1.
REQ-039 Back-to-back stream of 8 vectors with out_ready=1 -> 8 results on 8 consecutive cycles, in order, first result 2 cycles after the first input.
REQ-040 Stream with out_ready dropped for 3 cycles while out_valid=1:
- in_ready=0 for those 3 cycles;
- outputs stay stable while stalled;
- no result is lost or duplicated.
REQ-041 Reset asserted while 2 vectors are in flight -> out_valid falls immediately and no stale result appears after release.
REQ-042 N_IN=8, WIDTH=8: all operands 0x80 -> sum=0x400, so out=0x00, carry=3'b100, overflow=1, latency 3 cycles.

Source files
------------

// File: rtl/comp_sum_pkg.sv
// Shared types and elaboration-time helpers for the comp_sum adder tree.
`default_nettype none

package comp_sum_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } sum_mode_e;

   // log2 of a power of two
   function automatic int log2_pow2(input int n);
      int r;
      r = 0;
      for (int v = n; v > 1; v = v >> 1) r++;
      return r;
   endfunction

   // Bit offset of tree level k inside the flat bus holding every level back to back
   function automatic int level_offset(input int n_in, input int width, input int k);
      int off;
      off = 0;
      for (int j = 0; j < k; j++) off += (n_in >> j) * (width + j);
      return off;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comp_sum_stage.sv
// One registered adder-tree level: sums adjacent operand pairs into values one bit wider.
`default_nettype none

module comp_sum_stage
   import comp_sum_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int IN_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       hold,
   input  logic                       in_valid,
   input  sum_mode_e                  in_mode,
   input  logic [N_IN-1:0][IN_W-1:0]  in_data,
   output logic                       out_valid,
   output sum_mode_e                  out_mode,
   output logic [N_IN/2-1:0][IN_W:0]  out_data
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_mode  <= MODE_WRAP;
         out_data  <= '0;
      end else if (!hold) begin
         out_valid <= in_valid;
         out_mode  <= in_mode;
         for (int i = 0; i < N_IN / 2; i++) begin
            out_data[i] <= {1'b0, in_data[2*i]} + {1'b0, in_data[2*i+1]};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/comp_sum_tree.sv
// Pipelined unsigned adder tree with wrap/saturate output, carry report and output backpressure.
`default_nettype none

module comp_sum_tree
   import comp_sum_pkg::*;
#(
   parameter  int N_IN  = 4,
   parameter  int WIDTH = 16,
   localparam int LVL   = log2_pow2(N_IN)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_IN-1:0][WIDTH-1:0]  vals,
   input  logic                        sat_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out,
   output logic [LVL-1:0]              carry,
   output logic                        overflow
);

   localparam int TOTAL   = level_offset(N_IN, WIDTH, LVL + 1);
   localparam int SUM_OFF = level_offset(N_IN, WIDTH, LVL);

   // Every tree level lives in one flat bus; level 0 is the raw operand vector
   wire [TOTAL-1:0]   tree;
   wire [LVL:0]       vld;
   sum_mode_e         mode [LVL:0];
   logic              hold;
   logic [WIDTH+LVL-1:0] sum;

   assign hold     = out_valid & ~out_ready;
   assign in_ready = ~hold;

   assign tree[N_IN*WIDTH-1:0] = vals;
   assign vld[0]  = in_valid;
   assign mode[0] = sat_en ? MODE_SAT : MODE_WRAP;

   generate
      for (genvar k = 1; k <= LVL; k++) begin : g_lvl
         localparam int NI    = N_IN >> (k - 1);
         localparam int WI    = WIDTH + k - 1;
         localparam int OFF_I = level_offset(N_IN, WIDTH, k - 1);
         localparam int OFF_O = level_offset(N_IN, WIDTH, k);

         comp_sum_stage #(
            .N_IN (NI),
            .IN_W (WI)
         ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .hold      (hold),
            .in_valid  (vld[k-1]),
            .in_mode   (mode[k-1]),
            .in_data   (tree[OFF_I +: NI*WI]),
            .out_valid (vld[k]),
            .out_mode  (mode[k]),
            .out_data  (tree[OFF_O +: (NI/2)*(WI+1)])
         );
      end
   endgenerate

   // Saturation is purely combinational on the last registered level
   assign sum       = tree[SUM_OFF +: WIDTH+LVL];
   assign out_valid = vld[LVL];
   assign carry     = sum[WIDTH+LVL-1:WIDTH];
   assign overflow  = |carry;
   assign out       = (mode[LVL] == MODE_SAT && overflow) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_comp_sum_tree.sv
// Randomized scoreboard bench for comp_sum_tree (4x16 streaming instance plus an 8x8 instance).
`default_nettype none

module tb_comp_sum_tree;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int L  = 2;
   localparam int NB = 8;
   localparam int WB = 8;
   localparam int LB = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                 a_in_valid, a_in_ready, a_sat, a_out_valid, a_out_ready, a_ovf;
   logic [N-1:0][W-1:0]  a_vals;
   logic [W-1:0]         a_out;
   logic [L-1:0]         a_carry;

   logic                   b_in_valid, b_in_ready, b_sat, b_out_valid, b_out_ready, b_ovf;
   logic [NB-1:0][WB-1:0]  b_vals;
   logic [WB-1:0]          b_out;
   logic [LB-1:0]          b_carry;

   comp_sum_tree #(.N_IN(N), .WIDTH(W)) u_dut_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .vals(a_vals), .sat_en(a_sat), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out(a_out), .carry(a_carry), .overflow(a_ovf)
   );

   comp_sum_tree #(.N_IN(NB), .WIDTH(WB)) u_dut_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .vals(b_vals), .sat_en(b_sat), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out(b_out), .carry(b_carry), .overflow(b_ovf)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      longint unsigned out;
      longint unsigned carry;
      bit              ovf;
      longint          stamp;
   } exp_t;

   // Reference: full-precision sum split into low WIDTH bits and the carry above them
   function automatic exp_t model(input longint unsigned sum, input int w, input bit sat);
      exp_t e;
      longint unsigned lim;
      lim     = (64'd1 << w) - 64'd1;
      e.carry = sum >> w;
      e.ovf   = (e.carry != 0);
      e.out   = (sat && e.ovf) ? lim : (sum & lim);
      e.stamp = 0;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      case ($urandom % 3)
         0:       return W'($urandom);
         1:       return 16'hFFFF - W'($urandom_range(0, 15));
         default: return W'($urandom_range(0, 15));
      endcase
   endfunction

   exp_t            q[$];
   longint          cyc = 0;
   longint          stalls = 0;
   logic            prev_hold = 1'b0;
   logic [W-1:0]    prev_out;
   logic [L-1:0]    prev_carry;
   logic            prev_ovf, prev_valid;

   // Monitor for instance A: handshakes are evaluated mid-cycle, ahead of the edge that commits them
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            exp_t e;
            longint unsigned sum;
            check("in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
            if (prev_hold) begin
               check("stall_out", a_out, prev_out);
               check("stall_carry", a_carry, prev_carry);
               check("stall_ovf", a_ovf, prev_ovf);
               check("stall_valid", a_out_valid, prev_valid);
            end
            if (a_out_valid && a_out_ready) begin
               if (q.size() == 0) begin
                  check("extra_result", a_out_valid, 1'b0);
               end else begin
                  e = q.pop_front();
                  check("out", a_out, e.out);
                  check("carry", a_carry, e.carry);
                  check("overflow", a_ovf, e.ovf);
                  check("latency", cyc - stalls, e.stamp + L);
               end
            end
            if (a_in_valid && a_in_ready) begin
               sum = 0;
               for (int i = 0; i < N; i++) sum += a_vals[i];
               e       = model(sum, W, a_sat);
               e.stamp = cyc - stalls;
               q.push_back(e);
            end
            if (a_out_valid && !a_out_ready) stalls++;
            prev_hold  = a_out_valid && !a_out_ready;
            prev_out   = a_out;
            prev_carry = a_carry;
            prev_ovf   = a_ovf;
            prev_valid = a_out_valid;
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   task automatic send_a(input bit v, input bit s, input logic [N-1:0][W-1:0] vv);
      @(posedge clk);
      #1;
      a_in_valid = v;
      a_sat      = s;
      a_vals     = vv;
   endtask

   task automatic send_a_rand(input bit v);
      logic [N-1:0][W-1:0] vv;
      for (int i = 0; i < N; i++) vv[i] = rnd_op();
      send_a(v, 1'($urandom), vv);
   endtask

   task automatic run_b(input logic [NB-1:0][WB-1:0] v, input bit s);
      longint unsigned sum;
      exp_t e;
      sum = 0;
      for (int i = 0; i < NB; i++) sum += v[i];
      e = model(sum, WB, s);
      @(posedge clk);
      #1;
      b_in_valid = 1'b1;
      b_vals     = v;
      b_sat      = s;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      for (int c = 1; c < LB; c++) begin
         check("b_early_valid", b_out_valid, 1'b0);
         @(posedge clk);
         #1;
      end
      check("b_valid", b_out_valid, 1'b1);
      check("b_out", b_out, e.out);
      check("b_carry", b_carry, e.carry);
      check("b_overflow", b_ovf, e.ovf);
      @(posedge clk);
      #1;
      check("b_single_result", b_out_valid, 1'b0);
   endtask

   initial begin
      logic [NB-1:0][WB-1:0] bv;
      reset       = 1'b1;
      a_in_valid  = 1'b0;
      a_sat       = 1'b0;
      a_vals      = '0;
      a_out_ready = 1'b1;
      b_in_valid  = 1'b0;
      b_sat       = 1'b0;
      b_vals      = '0;
      b_out_ready = 1'b1;
      #12;
      check("rst_out_valid", a_out_valid, 1'b0);
      check("rst_in_ready", a_in_ready, 1'b1);
      check("rst_out", a_out, 16'h0);
      check("rst_carry", a_carry, 2'b00);
      check("rst_overflow", a_ovf, 1'b0);
      check("rst_b_out_valid", b_out_valid, 1'b0);
      check("rst_b_out", b_out, 8'h0);

      // Directed vectors, the first one presented together with reset release
      @(posedge clk);
      #1;
      reset      = 1'b0;
      a_in_valid = 1'b1;
      a_sat      = 1'b0;
      a_vals     = {16'd4, 16'd3, 16'd2, 16'd1};
      send_a(1'b1, 1'b0, {N{16'hFFFF}});
      send_a(1'b1, 1'b1, {N{16'hFFFF}});
      send_a(1'b0, 1'b0, '0);
      repeat (4) send_a(1'b0, 1'b0, '0);

      // Back-to-back stream
      repeat (8) send_a_rand(1'b1);
      repeat (4) send_a(1'b0, 1'b0, '0);

      // Stream with a 3-cycle downstream stall while a result is waiting
      for (int i = 0; i < 12; i++) begin
         send_a_rand(1'b1);
         if (i == 4) a_out_ready = 1'b0;
         if (i == 7) a_out_ready = 1'b1;
         if (i >= 4 && i < 7) begin
            #1;
            check("stall_in_ready_low", a_in_ready, 1'b0);
         end
      end
      repeat (4) send_a(1'b0, 1'b0, '0);

      // Random traffic with random backpressure and bubbles
      for (int i = 0; i < 300; i++) begin
         send_a_rand(($urandom % 4) != 0);
         a_out_ready = (($urandom % 4) != 0);
      end
      a_out_ready = 1'b1;
      repeat (6) send_a(1'b0, 1'b0, '0);

      // Reset with two vectors in flight
      send_a_rand(1'b1);
      send_a_rand(1'b1);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      #1;
      check("pre_reset_valid", a_out_valid, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", a_out_valid, 1'b0);
      check("mid_rst_in_ready", a_in_ready, 1'b1);
      check("mid_rst_out", a_out, 16'h0);
      check("mid_rst_carry", a_carry, 2'b00);
      q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (6) send_a(1'b0, 1'b0, '0);

      // 8-operand instance
      run_b({NB{8'h80}}, 1'b0);
      run_b({NB{8'hFF}}, 1'b1);
      run_b({NB{8'h10}}, 1'b1);
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < NB; i++) bv[i] = WB'($urandom);
         run_b(bv, 1'($urandom));
      end

      check("leftover_results", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
